// File: rtl/frequency_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : frequency_meter
//  Purpose  : Measures the period of an external pulse train in clk cycles and
//             converts it to a frequency in 0.1 kHz units with a sequential
//             restoring divider (one quotient bit per clock).
//  Revision : 1.0  initial release
// ============================================================================
module frequency_meter #(
    parameter int CLK_FREQ_KHZ = 100_000,
    parameter int MAX_PERIOD   = 200_000,
    parameter int BIT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pulse_in,
    output logic [15:0]          meas_freq,
    output logic [BIT_WIDTH-1:0] meas_period,
    output logic                 freq_valid,
    output logic                 timeout,
    output logic                 busy
);

    // Dividend of the conversion: clk frequency expressed in 0.1 kHz units
    localparam logic [BIT_WIDTH-1:0] c_TARGET     = BIT_WIDTH'(CLK_FREQ_KHZ * 10);
    localparam logic [BIT_WIDTH-1:0] c_MAX_PERIOD = BIT_WIDTH'(MAX_PERIOD);
    localparam logic [BIT_WIDTH-1:0] c_FREQ_MAX   = BIT_WIDTH'(16'hFFFF);
    localparam int                   c_IW         = $clog2(BIT_WIDTH);
    localparam logic [c_IW-1:0]      c_LAST_ITER  = c_IW'(BIT_WIDTH - 1);

    localparam logic [1:0] c_ST_ARM     = 2'd0;
    localparam logic [1:0] c_ST_MEASURE = 2'd1;
    localparam logic [1:0] c_ST_DIVIDE  = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_s3;
    logic                 w_rise;
    logic [BIT_WIDTH-1:0] r_cnt;
    logic [1:0]           r_state;
    logic [BIT_WIDTH-1:0] r_divisor;
    logic [BIT_WIDTH-1:0] r_dividend;
    logic [BIT_WIDTH-1:0] r_rem;
    logic [BIT_WIDTH-1:0] r_quot;
    logic [c_IW-1:0]      r_iter;
    logic [15:0]          r_meas_freq;
    logic [BIT_WIDTH-1:0] r_meas_period;
    logic                 r_freq_valid;
    logic                 r_timeout;
    logic                 r_busy;
    logic [BIT_WIDTH:0]   w_rem_shift;
    logic                 w_rem_ge;
    logic [BIT_WIDTH-1:0] w_rem_next;
    logic                 w_quot_sat;

    assign w_rise = r_s2 & ~r_s3;

    // One restoring-division step: shift the next dividend bit into the
    // remainder and subtract the divisor when it fits. The remainder after a
    // successful subtract is below the divisor, so BIT_WIDTH bits suffice.
    assign w_rem_shift = {r_rem, r_dividend[BIT_WIDTH-1]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_divisor});
    assign w_rem_next  = w_rem_ge ? (w_rem_shift[BIT_WIDTH-1:0] - r_divisor)
                                  : w_rem_shift[BIT_WIDTH-1:0];
    assign w_quot_sat  = (r_quot > c_FREQ_MAX);

    assign meas_freq   = r_meas_freq;
    assign meas_period = r_meas_period;
    assign freq_valid  = r_freq_valid;
    assign timeout     = r_timeout;
    assign busy        = r_busy;

    // Two-flop synchronizer plus one delay flop for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pulse_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Period counter: restarts at 1 on every rise, saturates at MAX_PERIOD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= BIT_WIDTH'(1);
        end else if (r_cnt < c_MAX_PERIOD) begin
            r_cnt <= r_cnt + BIT_WIDTH'(1);
        end
    end

    // Measurement FSM with the divider datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_ST_ARM;
            r_divisor     <= '0;
            r_dividend    <= '0;
            r_rem         <= '0;
            r_quot        <= '0;
            r_iter        <= '0;
            r_meas_freq   <= '0;
            r_meas_period <= '0;
            r_freq_valid  <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;
            case (r_state)
                c_ST_ARM: begin
                    // First edge only opens the measurement window
                    if (w_rise) begin
                        r_state <= c_ST_MEASURE;
                    end
                end
                c_ST_MEASURE: begin
                    // A rise wins over a simultaneous counter saturation
                    if (w_rise) begin
                        r_divisor  <= r_cnt;
                        r_dividend <= c_TARGET;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_iter     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= c_ST_DIVIDE;
                    end else if (r_cnt == c_MAX_PERIOD) begin
                        r_meas_freq   <= '0;
                        r_meas_period <= '0;
                        r_timeout     <= 1'b1;
                        r_freq_valid  <= 1'b1;
                        r_state       <= c_ST_ARM;
                    end
                end
                c_ST_DIVIDE: begin
                    r_rem      <= w_rem_next;
                    r_dividend <= {r_dividend[BIT_WIDTH-2:0], 1'b0};
                    r_quot     <= {r_quot[BIT_WIDTH-2:0], w_rem_ge};
                    r_iter     <= r_iter + c_IW'(1);
                    if (r_iter == c_LAST_ITER) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    // Period is published together with the frequency so all
                    // outputs change on the same strobe
                    r_meas_freq   <= w_quot_sat ? 16'hFFFF : r_quot[15:0];
                    r_meas_period <= r_divisor;
                    r_timeout     <= 1'b0;
                    r_freq_valid  <= 1'b1;
                    r_state       <= c_ST_MEASURE;
                end
                default: begin
                    r_state <= c_ST_ARM;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frequency_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_frequency_meter
//  Purpose  : Scoreboard bench for frequency_meter. Rise times are turned into
//             expected results by an event-level model; a monitor pops and
//             compares on every freq_valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frequency_meter;

    localparam int BW   = 32;
    localparam int MAXP = 5000;
    localparam int TGT  = 1_000_000;
    localparam int LAT  = BW + 1;   // capture edge to freq_valid edge

    typedef struct {
        int freq;
        int period;
        bit tmo;
        int t;
    } exp_t;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          pulse_in = 1'b0;
    logic [15:0]   meas_freq;
    logic [BW-1:0] meas_period;
    logic          freq_valid;
    logic          timeout;
    logic          busy;

    exp_t sb[$];
    int   g[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    bit   prev_v = 1'b0;
    bit   prev_b = 1'b0;
    int   bcnt   = 0;

    frequency_meter #(
        .CLK_FREQ_KHZ (100_000),
        .MAX_PERIOD   (MAXP),
        .BIT_WIDTH    (BW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .meas_freq   (meas_freq),
        .meas_period (meas_period),
        .freq_valid  (freq_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_cap(input int r, input int per, input int x);
        exp_t e;
        if (r + LAT < x) begin
            e.freq   = (TGT / per > 65535) ? 65535 : TGT / per;
            e.period = per;
            e.tmo    = 1'b0;
            e.t      = r + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic push_to(input int tc, input int x);
        exp_t e;
        if (tc < x) begin
            e.freq   = 0;
            e.period = 0;
            e.tmo    = 1'b1;
            e.t      = tc;
            sb.push_back(e);
        end
    endtask

    // Event model: e[] are the clk edges at which each rise is acted on,
    // x is the edge after which reset cuts the segment short.
    task automatic model(input int e[$], input int x);
        bit arm;
        int last;
        int ms;
        int tc;
        int r;
        arm  = 1'b1;
        last = 0;
        ms   = 0;
        foreach (e[i]) begin
            r = e[i];
            if (!arm) begin
                if (r < ms) begin
                    last = r;      // edge during conversion: restarts count only
                    continue;
                end
                tc = (last + MAXP > ms) ? last + MAXP : ms;
                if (tc < r) begin
                    push_to(tc, x);
                    arm = 1'b1;
                end else begin
                    push_cap(r, (r - last > MAXP) ? MAXP : r - last, x);
                    last = r;
                    ms   = r + LAT + 1;
                    continue;
                end
            end
            arm  = 1'b0;
            last = r;
            ms   = r + 1;
        end
        if (!arm) begin
            tc = (last + MAXP > ms) ? last + MAXP : ms;
            push_to(tc, x);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({meas_freq, meas_period, freq_valid, timeout, busy} !== '0) begin
            errors++;
            $display("FAIL %s: got freq=%0d period=%0d valid=%0b timeout=%0b busy=%0b, required all 0",
                     name, meas_freq, meas_period, freq_valid, timeout, busy);
        end
    endtask

    task automatic add(input int v, input int n);
        repeat (n) g.push_back(v);
    endtask

    task automatic add_rand(input int n);
        repeat (n) begin
            if ($urandom_range(9, 0) == 0) g.push_back(int'($urandom_range(5100, 4900)));
            else                           g.push_back(int'($urandom_range(400, 2)));
        end
    endtask

    // One segment: release reset, drive rises spaced by gaps, then assert
    // reset asynchronously tail cycles after the last rise.
    task automatic run_seg(input int gaps[$], input int tail);
        int p[$];
        int e[$];
        int hi[$];
        int x;
        @(negedge clk);
        reset = 1'b1;
        p.push_back(cyc + 4);
        foreach (gaps[i]) p.push_back(p[i] + gaps[i]);
        foreach (p[i]) begin
            e.push_back(p[i] + 3);
            hi.push_back((i < gaps.size() && gaps[i] / 2 > 0) ? gaps[i] / 2 : 1);
        end
        x = p[p.size() - 1] + tail;
        model(e, x);
        foreach (p[i]) begin
            wait_to(p[i]);
            pulse_in = 1'b1;
            wait_to(p[i] + hi[i]);
            pulse_in = 1'b0;
        end
        wait_to(x - 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_zero("reset_async");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_valid: got %0d results still pending, required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
        g.delete();
    endtask

    // Monitor: compare every strobe against the oldest expected result
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (reset && freq_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got freq=%0d period=%0d timeout=%0b at cycle %0d, required no strobe",
                             meas_freq, meas_period, timeout, cyc);
                end else begin
                    x = sb.pop_front();
                    if (meas_freq !== 16'(x.freq) || meas_period !== BW'(x.period) ||
                        timeout !== x.tmo || cyc != x.t || prev_v ||
                        (!x.tmo && bcnt != BW)) begin
                        errors++;
                        $display("FAIL result: got freq=%0d period=%0d timeout=%0b cycle=%0d busy_len=%0d back_to_back=%0b, required freq=%0d period=%0d timeout=%0b cycle=%0d busy_len=%0d back_to_back=0",
                                 meas_freq, meas_period, timeout, cyc, bcnt, prev_v,
                                 x.freq, x.period, x.tmo, x.t, x.tmo ? bcnt : BW);
                    end
                end
            end
            if (busy) bcnt = prev_b ? bcnt + 1 : 1;
            prev_b = busy;
            prev_v = freq_valid;
        end
    end

    initial begin
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_values");

        add(2000, 3);                 run_seg(g, 100);   // nominal
        add(1999, 3); add(3000, 3);   run_seg(g, 100);   // truncation
        add(16, 10);                  run_seg(g, 100);   // 62500
        add(4, 30);                   run_seg(g, 100);   // saturation
        add(2000, 2); add(6000, 1); add(4000, 2);
                                      run_seg(g, 100);   // timeout and recovery
        add(5000, 2); add(5001, 1);   run_seg(g, 100);   // boundary
        add(2000, 2);                 run_seg(g, 13);    // reset at DIVIDE iteration 10
        add(2000, 2);                 run_seg(g, 100);   // re-arm after reset
        add_rand(14);                 run_seg(g, 60);
        add_rand(14);                 run_seg(g, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
